fpadd_issue_arbiter: RTL and testbench

Round-robin issue arbiter that shares one pipelined floating-point adder/subtractor (`fpadd`, fixed latency) among `N_REQ` requesters in the cluster Jacobi datapath. Each requester presents an operand pair and op over a valid/ready handshake. The arbiter grants at most one per cycle, registers the operands into the adder, and carries a requester tag down a shift pipe matched to the adder latency. It returns each result to its owner with a one-cycle response strobe.

---
 rtl/jacobi_pkg.sv | 16 +
 rtl/fpadd_issue_arbiter_rr_pick.sv | 30 +++
 rtl/fpadd_issue_arbiter.sv | 136 +++++++++++++
 tb/tb_fpadd_issue_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jacobi_pkg.sv
// Shared constants for the cluster Jacobi floating-point datapath.
// The arbiter and the fpadd instance both read the latency from here so they stay in step.
package jacobi_pkg;

  localparam int          FP_W             = 32;
  localparam logic [30:0] FP_NEG_ZERO_MASK = 31'h7FFFFFFF;
  localparam int          FPADD_LATENCY    = 2;

  typedef logic [FP_W-1:0] fp_word_t;

  // Folds -0.0 onto +0.0 so the adder only ever sees one encoding of zero.
  function automatic fp_word_t fp_clear_neg_zero(input fp_word_t v);
    return ((v[FP_W-2:0] & FP_NEG_ZERO_MASK) == '0) ? '0 : v;
  endfunction

endpackage

// File: rtl/fpadd_issue_arbiter_rr_pick.sv
// Combinational round-robin pick: the first set request strictly after 'last', wrapping around.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Walk the requests from last+1 to last (inclusive) and stop at the first one set.
  always_comb begin
    logic [IW-1:0] pos;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(last) + k) % N);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = pos;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpadd_issue_arbiter.sv
// Round-robin issue arbiter that shares one pipelined fpadd among N_REQ requesters.
// Operands are registered into the adder and a requester tag follows them down a pipe
// matched to the adder latency, so each result is strobed back to its owner.
module fpadd_issue_arbiter
  import jacobi_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = FPADD_LATENCY,
  parameter int W       = FP_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0]              req_lock,
  input  logic [N_REQ*W-1:0]            req_a,
  input  logic [N_REQ*W-1:0]            req_b,
  input  logic [N_REQ-1:0]              req_op,
  output logic [W-1:0]                  add_a,
  output logic [W-1:0]                  add_b,
  output logic                          add_op,
  output logic                          add_start,
  input  logic [W-1:0]                  add_result,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [W-1:0]                  rsp_data,
  output logic [$clog2(LATENCY+2)-1:0]  inflight
);

  localparam int TW = $clog2(N_REQ);
  localparam int CW = $clog2(LATENCY + 2);

  logic [TW-1:0]    last_q;
  logic [N_REQ-1:0] rot_grant;
  logic [TW-1:0]    rot_idx;
  logic             rot_found;
  logic             lock_hit;

  logic [N_REQ-1:0] grant;
  logic [TW-1:0]    grant_idx;
  logic             grant_any;

  logic [TW-1:0]    issue_tag;
  logic [LATENCY-1:0] pipe_v;
  logic [TW-1:0]    pipe_tag [LATENCY];
  logic             rsp_any;

  rr_pick #(.N(N_REQ), .IW(TW)) u_pick (
    .req   (req_valid),
    .last  (last_q),
    .grant (rot_grant),
    .idx   (rot_idx),
    .found (rot_found)
  );

  assign lock_hit = req_lock[last_q] & req_valid[last_q];

  // A locked, still-valid owner beats rotation; nothing is granted while issue is disabled.
  always_comb begin
    grant     = '0;
    grant_idx = last_q;
    grant_any = 1'b0;
    if (en) begin
      if (lock_hit) begin
        grant[last_q] = 1'b1;
        grant_any     = 1'b1;
      end else if (rot_found) begin
        grant     = rot_grant;
        grant_idx = rot_idx;
        grant_any = 1'b1;
      end
    end
  end

  assign req_ready = grant;

  // Remember the last winner so the next search starts just after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= TW'(N_REQ - 1);
    else if (grant_any) last_q <= grant_idx;
  end

  // Issue register: capture the winner's operands, with -0.0 folded to +0.0; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a     <= '0;
      add_b     <= '0;
      add_op    <= 1'b0;
      add_start <= 1'b0;
      issue_tag <= '0;
    end else begin
      add_start <= grant_any;
      if (grant_any) begin
        add_a     <= fp_clear_neg_zero(req_a[int'(grant_idx)*W +: W]);
        add_b     <= fp_clear_neg_zero(req_b[int'(grant_idx)*W +: W]);
        add_op    <= req_op[grant_idx];
        issue_tag <= grant_idx;
      end
    end
  end

  // Tag pipe: the owner of each issued operation travels alongside it through the adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int s = 0; s < LATENCY; s++) pipe_tag[s] <= '0;
    end else begin
      pipe_v[0]   <= add_start;
      pipe_tag[0] <= issue_tag;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_v[s]   <= pipe_v[s-1];
        pipe_tag[s] <= pipe_tag[s-1];
      end
    end
  end

  assign rsp_any = pipe_v[LATENCY-1];

  // Decode the emerging tag into a one-hot strobe and gate the result word with it.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (rsp_any) begin
      rsp_valid[pipe_tag[LATENCY-1]] = 1'b1;
      rsp_data                       = add_result;
    end
  end

  // Count operations between grant and result strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= '0;
    else if (grant_any && !rsp_any) inflight <= inflight + CW'(1);
    else if (!grant_any && rsp_any) inflight <= inflight - CW'(1);
  end

endmodule

// File: tb/tb_fpadd_issue_arbiter.sv
// Bench for fpadd_issue_arbiter: table-driven arbitration vectors plus hand-written
// sequences, with a reference arbiter model and a result scoreboard keyed by due cycle.
module tb_fpadd_issue_arbiter;

  localparam int N = 4;
  localparam int L = 2;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en;
  logic [N-1:0]     req_valid, req_ready, req_lock, req_op, rsp_valid;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     add_a, add_b, add_result, rsp_data;
  logic             add_op, add_start;
  logic [1:0]       inflight;

  always #5 clk = ~clk;

  fpadd_issue_arbiter #(.N_REQ(N), .LATENCY(L), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_start(add_start),
    .add_result(add_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inflight(inflight)
  );

  // Single-precision helpers (normals and zero only, exact for the values used here).
  function automatic real fpToReal(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'h0) d = {f[31], 63'h0};
    else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] realToFp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'h0) return {d[63], 31'h0};
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] fpRef(input logic [31:0] a, input logic [31:0] b, input logic op);
    return realToFp(op ? fpToReal(a) - fpToReal(b) : fpToReal(a) + fpToReal(b));
  endfunction

  function automatic logic [31:0] sanitize(input logic [31:0] v);
    return (v[30:0] == 31'h0) ? 32'h0 : v;
  endfunction

  // Behavioural fpadd with a two-clock latency.
  logic [W-1:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= add_start ? fpRef(add_a, add_b, add_op) : 32'h0;
    s2 <= s1;
  end
  assign add_result = s2;

  typedef struct {
    int          due;
    logic [3:0]  who;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic       en;
    logic [3:0] valid;
    logic [3:0] lock;
    logic [3:0] exp_ready;
  } vec_t;
  vec_t tbl[$];

  int checks = 0;
  int passed = 0;
  int cycle  = 0;

  logic [1:0]  m_last;
  logic        m_start;
  logic [31:0] m_a, m_b;
  logic        m_op;
  int          m_inflight;
  logic [3:0]  p_grant;
  logic [1:0]  p_idx;
  logic        p_any;
  logic        p_rsp;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
  endtask

  task automatic modelReset();
    m_last     = 2'd3;
    m_start    = 1'b0;
    m_a        = '0;
    m_b        = '0;
    m_op       = 1'b0;
    m_inflight = 0;
    sbq.delete();
  endtask

  // Reference arbitration decision for the current inputs.
  task automatic predictGrant();
    p_grant = '0;
    p_idx   = m_last;
    p_any   = 1'b0;
    if (en) begin
      if (req_lock[m_last] && req_valid[m_last]) begin
        p_grant[m_last] = 1'b1;
        p_any = 1'b1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          logic [1:0] p;
          p = 2'((int'(m_last) + k) % N);
          if (!p_any && req_valid[p]) begin
            p_grant[p] = 1'b1;
            p_idx = p;
            p_any = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] v, input logic [3:0] lk, input int k);
    en        = e;
    req_valid = v;
    req_lock  = lk;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'h3F800000 + (32'(i) << 20);
      req_b[i*W +: W] = 32'h40000000 + (32'((i + k) % 4) << 20);
      req_op[i]       = 1'((i + k) % 2);
    end
  endtask

  task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i]       = op;
  endtask

  // Pre-edge comparison of every output against the model and scoreboard.
  task automatic checkOutput(input logic use_exp, input logic [3:0] exp_ready);
    logic [3:0]  ev;
    logic [31:0] ed;
    predictGrant();
    checkVal("req_ready", 64'(req_ready), use_exp ? 64'(exp_ready) : 64'(p_grant));
    checkVal("add_start", 64'(add_start), 64'(m_start));
    checkVal("add_a", 64'(add_a), 64'(m_a));
    checkVal("add_b", 64'(add_b), 64'(m_b));
    checkVal("add_op", 64'(add_op), 64'(m_op));
    ev = '0;
    ed = '0;
    if (sbq.size() > 0 && sbq[0].due == cycle) begin
      ev = sbq[0].who;
      ed = sbq[0].data;
      void'(sbq.pop_front());
    end
    p_rsp = (ev != 4'b0);
    checkVal("rsp_valid", 64'(rsp_valid), 64'(ev));
    checkVal("rsp_data", 64'(rsp_data), 64'(ed));
    checkVal("inflight", 64'(inflight), 64'(m_inflight));
  endtask

  // Advance one clock and move the model along with the handshake seen before the edge.
  task automatic stepClock();
    logic [31:0] a, b;
    logic        op;
    a  = sanitize(req_a[int'(p_idx)*W +: W]);
    b  = sanitize(req_b[int'(p_idx)*W +: W]);
    op = req_op[p_idx];
    @(posedge clk);
    #1;
    cycle++;
    if (p_any) begin
      m_a = a;
      m_b = b;
      m_op = op;
      m_start = 1'b1;
      m_last = p_idx;
      sbq.push_back('{cycle + L, p_grant, fpRef(a, b, op)});
    end else begin
      m_start = 1'b0;
    end
    m_inflight = m_inflight + (p_any ? 1 : 0) - (p_rsp ? 1 : 0);
  endtask

  task automatic runCycle(input logic e, input logic [3:0] v, input logic [3:0] lk, input int k,
                          input logic use_exp, input logic [3:0] exp_r);
    applyStimulus(e, v, lk, k);
    #3;
    checkOutput(use_exp, exp_r);
    stepClock();
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before the next edge.
  task automatic doReset();
    applyStimulus(1'b0, 4'b0000, 4'b0000, 0);
    rst_n = 1'b0;
    #1;
    checkVal("rst req_ready", 64'(req_ready), 64'h0);
    checkVal("rst add_a", 64'(add_a), 64'h0);
    checkVal("rst add_b", 64'(add_b), 64'h0);
    checkVal("rst add_op", 64'(add_op), 64'h0);
    checkVal("rst add_start", 64'(add_start), 64'h0);
    checkVal("rst rsp_valid", 64'(rsp_valid), 64'h0);
    checkVal("rst rsp_data", 64'(rsp_data), 64'h0);
    checkVal("rst inflight", 64'(inflight), 64'h0);
    modelReset();
    @(posedge clk);
    #1;
    cycle++;
    rst_n = 1'b1;
  endtask

  initial begin
    applyStimulus(1'b0, 4'b0000, 4'b0000, 0);
    modelReset();

    // Rotation from reset, then a five-cycle lock on requester 2, en gap, mixed patterns.
    for (int i = 0; i < 6; i++) tbl.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0001 << (i % 4)});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 4'b1111, 4'b0100, 4'b0100});
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 4'b1000});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000});
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0001});
    tbl.push_back('{1'b1, 4'b1010, 4'b0000, 4'b0010});
    tbl.push_back('{1'b1, 4'b1010, 4'b0000, 4'b1000});
    tbl.push_back('{1'b1, 4'b1010, 4'b1000, 4'b1000});
    tbl.push_back('{1'b1, 4'b0001, 4'b1000, 4'b0001});
    tbl.push_back('{1'b1, 4'b0110, 4'b0000, 4'b0010});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000});

    @(posedge clk);
    #1;
    doReset();

    // Single requester 1: 1.0 + 2.0 returns 3.0 to requester 1 three cycles later.
    applyStimulus(1'b1, 4'b0010, 4'b0000, 0);
    setReq(1, 32'h3F800000, 32'h40000000, 1'b0);
    #3;
    checkOutput(1'b1, 4'b0010);
    stepClock();
    applyStimulus(1'b1, 4'b0000, 4'b0000, 0);
    #3;
    checkVal("single add_start", 64'(add_start), 64'h1);
    checkOutput(1'b0, 4'b0000);
    stepClock();
    #3;
    checkOutput(1'b0, 4'b0000);
    stepClock();
    #3;
    checkVal("single rsp_valid", 64'(rsp_valid), 64'h2);
    checkVal("single rsp_data", 64'(rsp_data), 64'h40400000);
    checkOutput(1'b0, 4'b0000);
    stepClock();
    #3;
    checkVal("single inflight", 64'(inflight), 64'h0);
    checkOutput(1'b0, 4'b0000);
    stepClock();

    doReset();
    foreach (tbl[i]) runCycle(tbl[i].en, tbl[i].valid, tbl[i].lock, i, 1'b1, tbl[i].exp_ready);

    // Negative zero operands are issued as +0 and return +0.
    applyStimulus(1'b1, 4'b0001, 4'b0000, 0);
    setReq(0, 32'h80000000, 32'h80000000, 1'b1);
    #3;
    checkOutput(1'b1, 4'b0001);
    stepClock();
    applyStimulus(1'b1, 4'b0000, 4'b0000, 0);
    #3;
    checkVal("negzero add_a", 64'(add_a), 64'h0);
    checkVal("negzero add_b", 64'(add_b), 64'h0);
    checkOutput(1'b0, 4'b0000);
    stepClock();
    #3;
    checkOutput(1'b0, 4'b0000);
    stepClock();
    #3;
    checkVal("negzero rsp_valid", 64'(rsp_valid), 64'h1);
    checkVal("negzero rsp_data", 64'(rsp_data), 64'h0);
    checkOutput(1'b0, 4'b0000);
    stepClock();

    // Two issues, one idle cycle, then reset: dropped operations never strobe.
    runCycle(1'b1, 4'b0011, 4'b0000, 1, 1'b1, 4'b0010);
    runCycle(1'b1, 4'b0011, 4'b0000, 2, 1'b1, 4'b0001);
    runCycle(1'b1, 4'b0000, 4'b0000, 3, 1'b1, 4'b0000);
    doReset();
    for (int i = 0; i < 3; i++) runCycle(1'b1, 4'b0000, 4'b0000, i, 1'b1, 4'b0000);
    runCycle(1'b1, 4'b1111, 4'b0000, 0, 1'b1, 4'b0001);
    for (int i = 0; i < 4; i++) runCycle(1'b1, 4'b0000, 4'b0000, i, 1'b1, 4'b0000);

    checkVal("scoreboard drained", 64'(sbq.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
